// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding IF/ID from a req/ack instruction memory.
// Define FETCH_QUEUE_BYPASS_EN to forward an ack straight to the head when empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t        buf_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_addr;
  logic             inflight;
  logic             drop;

  logic      issue;
  logic      ack;
  logic      accept;
  logic      byp_hit;
  logic      byp_take;
  logic      push;
  logic      pop;
  logic      q_valid;
  fq_entry_t head;

  assign q_valid = (count != '0);

  // Reset gates issue so the request line drops the moment reset asserts.
  assign issue = rst_i && !inflight && start_i
              && !redirect_i && (count < CNT_MAX);

  assign mem_req_o  = inflight | issue;
  assign mem_addr_o = inflight ? req_addr
                    : (issue ? fetch_pc : '0);

  assign ack    = mem_ack_i & mem_req_o;
  assign accept = ack & !drop & !redirect_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_hit = accept && !q_valid;
`else
  assign byp_hit = 1'b0;
`endif

  assign byp_take = byp_hit & !stall_i;
  assign push     = accept & !byp_take;
  assign pop      = q_valid & !stall_i & !redirect_i;

  assign head = byp_hit ? fq_entry_t'{pc: mem_addr_o, instr: mem_data_i}
                        : buf_q[rd_ptr];

  assign valid_o = q_valid | byp_hit;
  assign instr_o = valid_o ? head.instr : NOP;
  assign pc_o    = valid_o ? head.pc : '0;

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_q[wr_ptr] <= fq_entry_t'{pc: mem_addr_o, instr: mem_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      req_addr <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (ack) begin
        inflight <= 1'b0;
      end else if (issue) begin
        inflight <= 1'b1;
        req_addr <= mem_addr_o;
      end

      if (redirect_i) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        // A held request still completes at its old address; mark it stale.
        drop     <= inflight & !ack;
      end else begin
        if (ack) begin
          drop <= 1'b0;
          if (!drop) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end

        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end

        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming table plus redirect/reset sequences.
// Adapts the early-valid expectations when FETCH_QUEUE_BYPASS_EN is defined.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int n_run  = 0;
  int n_fail = 0;
  int lat    = 0;
  int wait_cnt = 0;

  always #5 clk_i = ~clk_i;

  fetch_queue dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {12'hC0D, a[19:0]};
  endfunction

  // Memory model: ack after `lat` extra cycles of a held request.
  assign mem_data_i = mem_word(mem_addr_o);
  assign mem_ack_i  = mem_req_o && (wait_cnt >= lat);

  always @(posedge clk_i) begin
    if (!mem_req_o || mem_ack_i) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic        stall;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic ev,
                          input logic [31:0] epc);
    chk({nm, ".valid"}, {31'b0, valid_o}, {31'b0, ev});
    chk({nm, ".pc"}, pc_o, ev ? epc : 32'h0);
    chk({nm, ".instr"}, instr_o, ev ? mem_word(epc) : NOP);
  endtask

  task automatic chk_req(input string nm, input logic er,
                         input logic [31:0] ea);
    chk({nm, ".req"}, {31'b0, mem_req_o}, {31'b0, er});
    chk({nm, ".addr"}, mem_addr_o, er ? ea : 32'h0);
  endtask

  // Leaves the bench at the first negedge after reset release (cycle 0).
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    redirect_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;

    vecs[0]  = '{1'b1, BYP,  32'd0,  1'b1, 32'd0};
    vecs[1]  = '{1'b1, 1'b1, 32'd0,  1'b1, 32'd4};
    vecs[2]  = '{1'b1, 1'b1, 32'd0,  1'b1, 32'd8};
    vecs[3]  = '{1'b1, 1'b1, 32'd0,  1'b1, 32'd12};
    vecs[4]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[5]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[6]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd16};
    vecs[8]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd20};
    vecs[9]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd24};
    vecs[10] = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd28};
    vecs[11] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd32};
    vecs[12] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd36};

    repeat (3) @(negedge clk_i);
    start_i = 1'b1;
    #1;
    chk_req("reset", 1'b0, 32'h0);
    chk_head("reset", 1'b0, 32'h0);

    // Zero-wait stream: fill under stall, then drain in order.
    lat = 0;
    stall_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk_i);
      stall_i = vecs[i].stall;
      #1;
      chk_head($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
      chk_req($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
    end

    // 3-cycle memory, redirect while the fetch of 0x8 is outstanding.
    lat = 2;
    stall_i = 1'b0;
    do_reset();
    #1;
    chk_req("drop.c0", 1'b1, 32'h0);
    repeat (6) cyc();
    #1;
    chk_req("drop.c6", 1'b1, 32'h8);
    cyc();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    chk_req("drop.c7", 1'b1, 32'h8);
    cyc();
    redirect_i = 1'b0;
    #1;
    chk_req("drop.c8", 1'b1, 32'h8);
    chk_head("drop.c8", 1'b0, 32'h0);
    cyc();
    #1;
    chk_req("drop.c9", 1'b1, 32'h100);
    chk_head("drop.c9", 1'b0, 32'h0);
    repeat (2) cyc();
    #1;
    chk_head("drop.c11", BYP, 32'h100);
    cyc();
    #1;
    chk_head("drop.c12", !BYP, 32'h100);

    // Redirect coincident with an ack and a pop.
    lat = 1;
    stall_i = 1'b1;
    do_reset();
    repeat (2) cyc();
    #1;
    chk_head("coin.c2", 1'b1, 32'h0);
    chk_req("coin.c2", 1'b1, 32'h4);
    cyc();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    stall_i = 1'b0;
    #1;
    chk("coin.c3.ack", {31'b0, mem_ack_i}, 32'h1);
    chk_head("coin.c3", 1'b1, 32'h0);
    cyc();
    redirect_i = 1'b0;
    #1;
    chk_head("coin.c4", 1'b0, 32'h0);
    chk_req("coin.c4", 1'b1, 32'h40);
    cyc();
    #1;
    chk_head("coin.c5", BYP, 32'h40);
    cyc();
    #1;
    chk_head("coin.c6", !BYP, 32'h40);
    chk_req("coin.c6", 1'b1, 32'h44);

    // start_i drop: the outstanding request still lands in the queue.
    lat = 2;
    stall_i = 1'b1;
    do_reset();
    cyc();
    start_i = 1'b0;
    #1;
    chk_req("start.c1", 1'b1, 32'h0);
    repeat (2) cyc();
    #1;
    chk_req("start.c3", 1'b0, 32'h0);
    chk_head("start.c3", 1'b1, 32'h0);
    cyc();
    stall_i = 1'b0;
    #1;
    chk_head("start.c4", 1'b1, 32'h0);
    cyc();
    #1;
    chk_head("start.c5", 1'b0, 32'h0);
    chk_req("start.c5", 1'b0, 32'h0);

    // Reset asserted mid-request with two entries queued.
    start_i = 1'b1;
    lat = 0;
    stall_i = 1'b1;
    do_reset();
    repeat (2) cyc();
    lat = 5;
    #1;
    chk_req("rst.pre", 1'b1, 32'h8);
    chk_head("rst.pre", 1'b1, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    chk_req("rst.async", 1'b0, 32'h0);
    chk_head("rst.async", 1'b0, 32'h0);
    cyc();
    lat = 0;
    cyc();
    rst_i = 1'b1;
    stall_i = 1'b0;
    #1;
    chk_req("rst.restart", 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
